// File: rtl/c_fetch_align_ctrl_pkg.sv
// Shared types for the compressed-extension fetch path: FSM encodings, parcel type, and the
// helper that classifies a parcel as the low half of a 16-bit or 32-bit instruction.
package c_fetch_align_ctrl_pkg;

  localparam int PARCEL_W = 16;

  typedef logic [PARCEL_W-1:0] type_parcel_t;
  typedef logic [1:0]          type_fa_state_t;

  localparam logic [1:0] FA_IDLE  = 2'd0;
  localparam logic [1:0] FA_REQ   = 2'd1;
  localparam logic [1:0] FA_FLUSH = 2'd2;

  function automatic logic is_comp(input type_parcel_t p);
    return p[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/c_fetch_align_ctrl_if.sv
// I-cache request/response bus plus the instruction hand-off to the C decoder.
// The master side is the fetch controller; the slave side is the cache/decoder environment.
interface c_fetch_align_ctrl_if;

  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_kill_o;
  logic        icache_valid_i;
  logic [31:0] icache_word_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_comp_o;

  modport master (
    output icache_req_o, icache_addr_o, icache_kill_o,
    output instr_valid_o, instr_o, instr_pc_o, is_comp_o,
    input  icache_valid_i, icache_word_i, instr_ready_i
  );

  modport slave (
    input  icache_req_o, icache_addr_o, icache_kill_o,
    input  instr_valid_o, instr_o, instr_pc_o, is_comp_o,
    output icache_valid_i, icache_word_i, instr_ready_i
  );

endinterface

// File: rtl/c_fetch_align_ctrl_parcel_fifo.sv
// NUM_PARC x 16-bit parcel ring, 0/1/2 pushes and 0/1/2 pops per cycle, head0/head1 read combinationally.
// No internal overflow guard: the caller only pushes when its free-space rule leaves room.
module c_parcel_fifo
  import c_fetch_align_ctrl_pkg::*;
#(
  parameter int NUM_PARC = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [1:0]                push_n_i,
  input  type_parcel_t              push_lo_i,
  input  type_parcel_t              push_hi_i,
  input  logic [1:0]                pop_n_i,
  output type_parcel_t              head0_o,
  output type_parcel_t              head1_o,
  output logic [$clog2(NUM_PARC):0] count_o
);

  localparam int PW = $clog2(NUM_PARC);
  localparam int CW = PW + 1;

  type_parcel_t  mem_q [NUM_PARC];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [CW-1:0] count_q, count_d;

  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign rd_ptr_p1 = rd_ptr_q + PW'(1);
  assign head0_o   = mem_q[rd_ptr_q];
  assign head1_o   = mem_q[rd_ptr_p1];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_n_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_n_i);
    count_d  = count_q + CW'(push_n_i) - CW'(pop_n_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A single push carries only the upper parcel (word fetched for a 2-byte-aligned target).
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (push_n_i == 2'd1) begin
        mem_q[wr_ptr_q] <= push_hi_i;
      end else if (push_n_i == 2'd2) begin
        mem_q[wr_ptr_q]  <= push_lo_i;
        mem_q[wr_ptr_p1] <= push_hi_i;
      end
    end
  end

endmodule

// File: rtl/c_fetch_align_ctrl.sv
// Fetch-side aligner: word-aligned I-cache requests in, whole 16/32-bit instructions with PC out.
// Instruction outputs are combinational from the parcel buffer; fetch stalls when fewer than 2 parcels are free.
module c_fetch_align_ctrl
  import c_fetch_align_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_PARC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_taken_i,
  input  logic [31:0]          br_target_i,
  c_fetch_align_ctrl_if.master bus
);

  localparam int PW = $clog2(NUM_PARC);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;

  type_fa_state_t state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    head_pc_q, head_pc_d;
  logic           skip_lo_q, skip_lo_d;

  type_parcel_t   head0, head1;
  logic [CW-1:0]  count;
  logic [1:0]     push_n, pop_n;
  logic [FW-1:0]  free_after;
  logic           in_req, resp, head_comp, avail, pop;
  logic           unused_tgt_lsb;

  assign unused_tgt_lsb = br_target_i[0];

  assign in_req     = (state_q == FA_REQ);
  assign resp       = in_req && bus.icache_valid_i && !br_taken_i;
  assign push_n     = !resp ? 2'd0 : (skip_lo_q ? 2'd1 : 2'd2);
  assign head_comp  = is_comp(head0);
  // A redirect this cycle hides the stale head so nothing is popped.
  assign avail      = !br_taken_i && ((count >= CW'(1) && head_comp) || count >= CW'(2));
  assign pop        = avail && bus.instr_ready_i;
  assign pop_n      = !pop ? 2'd0 : (head_comp ? 2'd1 : 2'd2);
  assign free_after = FW'(NUM_PARC) - FW'(count) + FW'(pop_n);

  assign bus.icache_req_o  = in_req;
  assign bus.icache_addr_o = in_req ? fetch_pc_q : '0;
  assign bus.icache_kill_o = in_req && br_taken_i;
  assign bus.instr_valid_o = avail;
  assign bus.instr_o       = !avail ? '0 : (head_comp ? {16'h0000, head0} : {head1, head0});
  assign bus.instr_pc_o    = avail ? head_pc_q : '0;
  assign bus.is_comp_o     = avail && head_comp;

  c_parcel_fifo #(
    .NUM_PARC (NUM_PARC)
  ) u_parcel_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (br_taken_i),
    .push_n_i  (push_n),
    .push_lo_i (bus.icache_word_i[15:0]),
    .push_hi_i (bus.icache_word_i[31:16]),
    .pop_n_i   (pop_n),
    .head0_o   (head0),
    .head1_o   (head1),
    .count_o   (count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    skip_lo_d  = skip_lo_q;

    if (br_taken_i) begin
      fetch_pc_d = {br_target_i[31:2], 2'b00};
      head_pc_d  = {br_target_i[31:1], 1'b0};
      skip_lo_d  = br_target_i[1];
    end else begin
      if (resp) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        skip_lo_d  = 1'b0;
      end
      head_pc_d = head_pc_q + {29'd0, pop_n, 1'b0};
    end

    // A redirect seen in IDLE leaves the buffer empty, so the next fetch can start at once.
    unique case (state_q)
      FA_IDLE:  if (br_taken_i || free_after >= FW'(2)) state_d = FA_REQ;
      FA_REQ:   if (br_taken_i) state_d = FA_FLUSH;
                else if (bus.icache_valid_i) state_d = FA_IDLE;
      FA_FLUSH: if (!br_taken_i) state_d = FA_REQ;
      default:  state_d = FA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FA_IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      head_pc_q  <= {RESET_PC[31:1], 1'b0};
      skip_lo_q  <= RESET_PC[1];
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      skip_lo_q  <= skip_lo_d;
    end
  end

endmodule

// File: tb/tb_c_fetch_align_ctrl.sv
// Bench for c_fetch_align_ctrl: memory-image model of the instruction stream checked every cycle,
// plus directed scenarios with literal expectations.
module tb_c_fetch_align_ctrl;

  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = 32'h0;

  c_fetch_align_ctrl_if bus();

  c_fetch_align_ctrl #(
    .RESET_PC (32'h0000_0000),
    .NUM_PARC (NP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] img [256];
  logic [31:0] m_fetch = 32'h0;
  logic [31:0] m_pc    = 32'h0;
  int          cyc     = 0;
  int          n_vec   = 0;
  int          n_bad   = 0;
  int          lat     = 0;
  int          wcnt    = 0;

  logic [31:0] lg_pc [$];
  logic [31:0] lg_ins [$];
  logic        lg_cmp [$];
  int          lg_cyc [$];

  function automatic logic [15:0] parcel_at(input logic [31:0] a);
    logic [31:0] w;
    w = img[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream from the memory image: buffered parcels span [m_pc, m_fetch).
  always @(negedge clk) begin : cmp
    int          occ;
    logic [15:0] p0, p1;
    logic        cexp, vexp;
    logic [31:0] iexp;
    cyc++;
    if (reset) begin
      m_fetch = 32'h0;
      m_pc    = 32'h0;
    end else begin
      occ  = $signed(m_fetch - m_pc) >>> 1;
      p0   = parcel_at(m_pc);
      p1   = parcel_at(m_pc + 32'd2);
      cexp = (p0[1:0] != 2'b11);
      vexp = !br_taken_i && ((occ >= 1 && cexp) || occ >= 2);
      iexp = cexp ? {16'h0000, p0} : {p1, p0};
      check("occupancy_bound", 32'(occ <= NP), 32'd1);
      check("instr_valid", 32'(bus.instr_valid_o), 32'(vexp));
      check("icache_kill", 32'(bus.icache_kill_o), 32'(bus.icache_req_o && br_taken_i));
      if (vexp) begin
        check("instr", bus.instr_o, iexp);
        check("instr_pc", bus.instr_pc_o, m_pc);
        check("is_comp", 32'(bus.is_comp_o), 32'(cexp));
      end
      if (bus.icache_req_o) check("icache_addr", bus.icache_addr_o, m_fetch);
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        lg_pc.push_back(bus.instr_pc_o);
        lg_ins.push_back(bus.instr_o);
        lg_cmp.push_back(bus.is_comp_o);
        lg_cyc.push_back(cyc);
      end
      if (br_taken_i) begin
        m_fetch = {br_target_i[31:2], 2'b00};
        m_pc    = {br_target_i[31:1], 1'b0};
      end else begin
        if (bus.icache_req_o && bus.icache_valid_i) m_fetch = m_fetch + 32'd4;
        if (vexp && bus.instr_ready_i) m_pc = m_pc + (cexp ? 32'd2 : 32'd4);
      end
    end
  end

  // One clock; then the cache model answers a request after lat wait cycles.
  task automatic step();
    @(posedge clk);
    #1;
    br_taken_i = 1'b0;
    if (bus.icache_req_o && !reset) begin
      if (wcnt >= lat) begin
        bus.icache_valid_i = 1'b1;
        bus.icache_word_i  = img[bus.icache_addr_o[9:2]];
        wcnt = 0;
      end else begin
        bus.icache_valid_i = 1'b0;
        bus.icache_word_i  = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      bus.icache_valid_i = 1'b0;
      bus.icache_word_i  = 32'hDEAD_BEEF;
      wcnt = 0;
    end
  endtask

  task automatic fill_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h4501_4501;
  endtask

  task automatic clear_log();
    lg_pc.delete();
    lg_ins.delete();
    lg_cmp.delete();
    lg_cyc.delete();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check({tag, "_rst_req"},   32'(bus.icache_req_o), 32'd0);
    check({tag, "_rst_addr"},  bus.icache_addr_o, 32'd0);
    check({tag, "_rst_kill"},  32'(bus.icache_kill_o), 32'd0);
    check({tag, "_rst_valid"}, 32'(bus.instr_valid_o), 32'd0);
    check({tag, "_rst_instr"}, bus.instr_o, 32'd0);
    check({tag, "_rst_pc"},    bus.instr_pc_o, 32'd0);
    check({tag, "_rst_comp"},  32'(bus.is_comp_o), 32'd0);
    clear_log();
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait expired, got no event, expected one within bound", tag);
  endtask

  initial begin
    int k, n0, nresp;
    bus.icache_valid_i = 1'b0;
    bus.icache_word_i  = 32'h0;
    bus.instr_ready_i  = 1'b1;

    // 1: back-to-back compressed stream
    fill_img();
    lat = 0;
    do_reset("t1");
    step();
    #1;
    check("t1_addr0", bus.icache_addr_o, 32'h0);
    repeat (8) step();
    check("t1_npop", 32'(lg_pc.size() >= 3), 32'd1);
    if (lg_pc.size() >= 3) begin
      check("t1_pc0", lg_pc[0], 32'h0);
      check("t1_pc1", lg_pc[1], 32'h2);
      check("t1_pc2", lg_pc[2], 32'h4);
      check("t1_ins0", lg_ins[0], 32'h0000_4501);
      check("t1_comp0", 32'(lg_cmp[0]), 32'd1);
      check("t1_b2b", 32'(lg_cyc[2] - lg_cyc[0]), 32'd2);
    end

    // 2: 32-bit instruction straddling a word boundary
    fill_img();
    img[0] = 32'h0093_4501;
    img[1] = 32'hABCD_0513;
    lat = 2;
    do_reset("t2");
    repeat (20) step();
    check("t2_npop", 32'(lg_pc.size() >= 3), 32'd1);
    if (lg_pc.size() >= 3) begin
      check("t2_pc0", lg_pc[0], 32'h0);
      check("t2_ins0", lg_ins[0], 32'h0000_4501);
      check("t2_pc1", lg_pc[1], 32'h2);
      check("t2_ins1", lg_ins[1], 32'h0513_0093);
      check("t2_comp1", 32'(lg_cmp[1]), 32'd0);
      check("t2_wait", 32'(lg_cyc[1] - lg_cyc[0]), 32'd4);
      check("t2_pc2", lg_pc[2], 32'h6);
      check("t2_ins2", lg_ins[2], 32'h0000_ABCD);
    end

    // 3: redirect to a 2-byte-aligned target while a request is outstanding
    fill_img();
    img[64] = 32'h1111_0001;
    lat = 3;
    do_reset("t3");
    k = 0;
    while (!(bus.icache_req_o && !bus.icache_valid_i) && k < 30) begin step(); k++; end
    if (!(bus.icache_req_o && !bus.icache_valid_i)) timeout("t3_req");
    br_taken_i  = 1'b1;
    br_target_i = 32'h0000_0102;
    #1;
    check("t3_kill", 32'(bus.icache_kill_o), 32'd1);
    clear_log();
    step();
    #1;
    check("t3_flush_req", 32'(bus.icache_req_o), 32'd0);
    check("t3_flush_kill", 32'(bus.icache_kill_o), 32'd0);
    step();
    #1;
    check("t3_req_after", 32'(bus.icache_req_o), 32'd1);
    check("t3_addr_after", bus.icache_addr_o, 32'h0000_0100);
    repeat (12) step();
    check("t3_npop", 32'(lg_pc.size() >= 1), 32'd1);
    if (lg_pc.size() >= 1) begin
      check("t3_pc0", lg_pc[0], 32'h0000_0102);
      check("t3_ins0", lg_ins[0], 32'h0000_1111);
    end

    // 4: redirect coincident with a response and a pop
    fill_img();
    lat = 0;
    do_reset("t4");
    k = 0;
    while (!(bus.icache_valid_i && bus.instr_valid_o) && k < 30) begin step(); k++; end
    if (!(bus.icache_valid_i && bus.instr_valid_o)) timeout("t4_coincide");
    n0 = lg_pc.size();
    br_taken_i  = 1'b1;
    br_target_i = 32'h0000_0080;
    #1;
    check("t4_kill", 32'(bus.icache_kill_o), 32'd1);
    check("t4_valid_forced", 32'(bus.instr_valid_o), 32'd0);
    step();
    #1;
    check("t4_nopop", 32'(lg_pc.size()), 32'(n0));
    check("t4_empty", 32'(bus.instr_valid_o), 32'd0);
    repeat (10) step();
    check("t4_npop", 32'(lg_pc.size() > n0), 32'd1);
    if (lg_pc.size() > n0) check("t4_pc_target", lg_pc[n0], 32'h0000_0080);

    // 5: consumer stalled, buffer fills to exactly two words, then drains in order
    fill_img();
    lat = 1;
    bus.instr_ready_i = 1'b0;
    do_reset("t5");
    nresp = 0;
    repeat (14) begin
      step();
      if (bus.icache_req_o && bus.icache_valid_i) nresp++;
    end
    check("t5_words", 32'(nresp), 32'd2);
    check("t5_req_idle", 32'(bus.icache_req_o), 32'd0);
    check("t5_valid_held", 32'(bus.instr_valid_o), 32'd1);
    bus.instr_ready_i = 1'b1;
    clear_log();
    repeat (6) step();
    check("t5_npop", 32'(lg_pc.size() >= 4), 32'd1);
    if (lg_pc.size() >= 4) begin
      check("t5_pc0", lg_pc[0], 32'h0);
      check("t5_pc1", lg_pc[1], 32'h2);
      check("t5_pc2", lg_pc[2], 32'h4);
      check("t5_pc3", lg_pc[3], 32'h6);
      check("t5_drain", 32'(lg_cyc[3] - lg_cyc[0]), 32'd3);
    end

    // 6: reset while a request is outstanding mid-stream
    fill_img();
    lat = 3;
    do_reset("t6a");
    repeat (9) step();
    k = 0;
    while (!bus.icache_req_o && k < 30) begin step(); k++; end
    if (!bus.icache_req_o) timeout("t6_req");
    do_reset("t6b");
    k = 0;
    while (!bus.icache_req_o && k < 30) begin step(); k++; end
    if (!bus.icache_req_o) timeout("t6_restart");
    check("t6_addr_restart", bus.icache_addr_o, 32'h0);
    repeat (10) step();
    check("t6_npop", 32'(lg_pc.size() >= 1), 32'd1);
    if (lg_pc.size() >= 1) check("t6_pc0", lg_pc[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
